// File: rtl/clkdiv_pkg.sv
// Shared constants and elaboration-time helpers for the NCO clock divider.
package clkdiv_pkg;

  localparam int ACC_W_DEF    = 32;
  localparam int CHANNELS_DEF = 4;

  function automatic int calc_ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  localparam int CH_W = calc_ch_w(CHANNELS_DEF);

  // round(f1 * 2^acc_w / f0), clamped to half scale (out = f0/2)
  function automatic longint calc_inc(input longint f0, input longint f1, input int acc_w);
    longint num;
    longint inc;
    longint half;
    num  = (f1 << acc_w) + (f0 >> 1);
    inc  = num / f0;
    half = longint'(1) << (acc_w - 1);
    return (inc > half) ? half : inc;
  endfunction

endpackage

// File: rtl/clkdiv_nco_ch.sv
// One NCO divider channel: phase accumulator, deferred reprogramming at the
// period boundary, square-wave output and per-period strobe.
module clkdiv_nco_ch #(
  parameter int               ACC_W   = 32,
  parameter logic [ACC_W-1:0] INC_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  input  logic             wr_en,
  output logic             out,
  output logic             tick,
  output logic             pend
);

  localparam logic [ACC_W-1:0] INC_MAX = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] pend_inc;
  logic [ACC_W-1:0] wr_inc_sat;
  logic             en;
  logic             pend_en;
  logic             carry;
  logic [ACC_W:0]   sum;

  assign sum        = {1'b0, acc} + {1'b0, inc};
  assign carry      = en & sum[ACC_W];
  assign wr_inc_sat = (wr_inc > INC_MAX) ? INC_MAX : wr_inc;
  assign out        = acc[ACC_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      inc      <= INC_RST;
      en       <= 1'b1;
      pend     <= 1'b0;
      pend_inc <= '0;
      pend_en  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      acc  <= en ? sum[ACC_W-1:0] : '0;
      // the wrap that disables the channel already belongs to the idle state
      tick <= carry & ~(pend & ~pend_en);
      if (pend && carry) begin
        inc  <= pend_inc;
        en   <= pend_en;
        pend <= 1'b0;
        if (!pend_en) acc <= '0;
      end
      // cfg_ready guarantees wr never coincides with a pending apply
      if (wr) begin
        if (en) begin
          pend     <= 1'b1;
          pend_inc <= wr_inc_sat;
          pend_en  <= wr_en;
        end else begin
          inc <= wr_inc_sat;
          en  <= wr_en;
        end
      end
    end
  end

endmodule

// File: rtl/clkdiv_nco.sv
// Multi-channel programmable fractional clock divider; decodes configuration
// writes onto CHANNELS independent NCO channels.
module clkdiv_nco
  import clkdiv_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int F0       = 50_000_000,
  parameter int F1       = 15_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [calc_ch_w(CHANNELS)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]               cfg_inc,
  input  logic                           cfg_en,
  output logic [CHANNELS-1:0]            out,
  output logic [CHANNELS-1:0]            tick
);

  localparam int               CH_SEL_W = calc_ch_w(CHANNELS);
  localparam logic [ACC_W-1:0] INC_RST  = ACC_W'(calc_inc(longint'(F0), longint'(F1), ACC_W));

  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] wr;

  // out-of-range selects never match a channel, so they stay ready
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_ch == CH_SEL_W'(i)) cfg_ready = ~pend[i];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign wr[g] = cfg_valid & cfg_ready & (cfg_ch == CH_SEL_W'(g));

    clkdiv_nco_ch #(
      .ACC_W   (ACC_W),
      .INC_RST (INC_RST)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .wr     (wr[g]),
      .wr_inc (cfg_inc),
      .wr_en  (cfg_en),
      .out    (out[g]),
      .tick   (tick[g]),
      .pend   (pend[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_nco.sv
// Directed bench for clkdiv_nco with ACC_W=8, F0=256, F1=32 (INC_RST=32).
module tb_clkdiv_nco;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = 2'd0;
  logic [7:0] cfg_inc = 8'd0;
  logic       cfg_en = 1'b0;
  logic [3:0] out;
  logic [3:0] tick;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clkdiv_nco #(
    .CHANNELS (4),
    .ACC_W    (8),
    .F0       (256),
    .F1       (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_en    (cfg_en),
    .out       (out),
    .tick      (tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input logic [1:0] ch, input logic [7:0] inc, input logic en);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_inc   = inc;
    cfg_en    = en;
  endtask

  // all channels at inc=32 from acc=0: out high on cycles 4..7 of 8, tick after the wrap
  task automatic check_period8(input string tag);
    for (int n = 1; n <= 16; n++) begin
      step();
      check({tag, " out"},  {28'd0, out},  ((n % 8) >= 4) ? 32'hf : 32'h0);
      check({tag, " tick"}, {28'd0, tick}, ((n % 8) == 0) ? 32'hf : 32'h0);
    end
  endtask

  initial begin
    // reset
    step();
    step();
    check("rst out",   {28'd0, out},  32'h0);
    check("rst tick",  {28'd0, tick}, 32'h0);
    check("rst ready", {31'd0, cfg_ready}, 32'h1);
    rst = 1'b0;
    check_period8("t1");                           // E1..E16

    // ch1 inc=64 written when acc=96
    step(); step(); step();                        // E17..E19, acc=96
    drive_cfg(2'd1, 8'd64, 1'b1);
    check("t2 ready pre", {31'd0, cfg_ready}, 32'h1);
    step();                                        // E20 accept, acc=128
    cfg_valid = 1'b0;
    check("t2 ready pend", {31'd0, cfg_ready}, 32'h0);
    check("t2 out1 old",   {31'd0, out[1]},    32'h1);
    for (int k = 0; k < 3; k++) begin              // E21..E23
      step();
      check("t2 ready hold", {31'd0, cfg_ready}, 32'h0);
      check("t2 out1 hold",  {31'd0, out[1]},    32'h1);
    end
    step();                                        // E24 wrap, apply
    check("t2 ready apply", {31'd0, cfg_ready}, 32'h1);
    check("t2 tick1 wrap",  {31'd0, tick[1]},   32'h1);
    for (int k = 1; k <= 8; k++) begin             // E25..E32 period 4
      step();
      check("t2 out1 p4",  {31'd0, out[1]},  ((k % 4) >= 2) ? 32'h1 : 32'h0);
      check("t2 tick1 p4", {31'd0, tick[1]}, ((k % 4) == 0) ? 32'h1 : 32'h0);
    end

    // ch2 disabled mid-period
    step(); step();                                // E33,E34 acc=64
    drive_cfg(2'd2, 8'd32, 1'b0);
    check("t3 ready pre", {31'd0, cfg_ready}, 32'h1);
    step();                                        // E35 accept
    cfg_valid = 1'b0;
    check("t3 ready pend", {31'd0, cfg_ready}, 32'h0);
    for (int k = 0; k < 4; k++) begin              // E36..E39 period completes
      step();
      check("t3 out2 finish", {31'd0, out[2]}, 32'h1);
    end
    for (int k = 0; k < 9; k++) begin              // E40..E48
      step();
      check("t3 out2 off",  {31'd0, out[2]},  32'h0);
      check("t3 tick2 off", {31'd0, tick[2]}, 32'h0);
      check("t3 tick0",     {31'd0, tick[0]}, (k == 0 || k == 8) ? 32'h1 : 32'h0);
    end
    check("t3 ready idle", {31'd0, cfg_ready}, 32'h1);

    // ch2 re-enabled with inc=16 while disabled
    drive_cfg(2'd2, 8'd16, 1'b1);
    check("t4 ready pre", {31'd0, cfg_ready}, 32'h1);
    step();                                        // E49 accept, applied at once
    cfg_valid = 1'b0;
    check("t4 ready post", {31'd0, cfg_ready}, 32'h1);
    check("t4 out2 start", {31'd0, out[2]},    32'h0);
    for (int k = 1; k <= 16; k++) begin            // E50..E65
      step();
      check("t4 out2",  {31'd0, out[2]},  (k >= 8 && k <= 15) ? 32'h1 : 32'h0);
      check("t4 tick2", {31'd0, tick[2]}, (k == 16) ? 32'h1 : 32'h0);
    end

    // back-to-back writes to ch0; second saturates 200 -> 128
    drive_cfg(2'd0, 8'd64, 1'b1);                  // ch0 acc=32
    step();                                        // E66 accept first
    drive_cfg(2'd0, 8'd200, 1'b1);
    check("t5 ready stall", {31'd0, cfg_ready}, 32'h0);
    for (int k = 0; k < 5; k++) begin              // E67..E71
      step();
      check("t5 ready hold", {31'd0, cfg_ready}, 32'h0);
    end
    step();                                        // E72 wrap applies first write
    check("t5 ready free", {31'd0, cfg_ready}, 32'h1);
    check("t5 tick0 wrap", {31'd0, tick[0]},   32'h1);
    step();                                        // E73 accept second
    cfg_valid = 1'b0;
    check("t5 ready pend2", {31'd0, cfg_ready}, 32'h0);
    step();                                        // E74 acc=128
    check("t5 out0 p4", {31'd0, out[0]}, 32'h1);
    step();                                        // E75 acc=192
    step();                                        // E76 wrap applies inc=128
    check("t5 ready apply2", {31'd0, cfg_ready}, 32'h1);
    check("t5 out0 wrap",    {31'd0, out[0]},    32'h0);
    for (int k = 1; k <= 4; k++) begin             // E77..E80 toggle every clk
      step();
      check("t5 out0 sat",  {31'd0, out[0]},  (k % 2 == 1) ? 32'h1 : 32'h0);
      check("t5 tick0 sat", {31'd0, tick[0]}, (k % 2 == 0) ? 32'h1 : 32'h0);
    end

    // reset while ch3 has a pending write
    step(); step();                                // E81,E82 ch3 acc=64
    drive_cfg(2'd3, 8'd100, 1'b1);
    step();                                        // E83 accept
    cfg_valid = 1'b0;
    check("t6 ready pend", {31'd0, cfg_ready}, 32'h0);
    rst = 1'b1;
    step();                                        // E84 reset
    check("t6 rst out",   {28'd0, out},  32'h0);
    check("t6 rst tick",  {28'd0, tick}, 32'h0);
    check("t6 rst ready", {31'd0, cfg_ready}, 32'h1);
    rst = 1'b0;
    check_period8("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
